// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the display scan controller.
// Optional build macro DISP_BRIGHT_EN is consumed by display_scan_ctrl.
package disp_pkg;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam int DIGIT_W = 4;

  // All digit enables dark (active-low); wide enough for the largest digit count.
  localparam logic [7:0] AN_OFF = '1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/disp_dwell_cnt.sv
// disp_dwell_cnt: free-running dwell counter that reloads zero on reaching a
// caller-supplied limit. Exposes the next count so registered outputs can be
// computed against the value the counter will hold in the following cycle.
module disp_dwell_cnt #(
  parameter int  MAX_CNT = 4,
  localparam int CW      = $clog2(MAX_CNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] cnt_next,
  output logic          tc
);

  logic [CW-1:0] cnt;

  assign tc       = (cnt == limit);
  assign cnt_next = tc ? '0 : cnt + 1'b1;

  // Count up, wrapping to zero at the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_next;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed common-anode 7-segment scan controller.
// Rotates GUARD (all dark) -> DRIVE (one digit lit) per digit, holds the host
// written digit values and presents the active one to a shared decoder.
// Optional build macro DISP_BRIGHT_EN adds a brightness input (duty control).
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int  NUM_DIGITS = 4,
  parameter int  CLK_DIV    = 100000,
  parameter int  GUARD_CYC  = 16,
  localparam int IW         = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_idx,
  input  logic [DIGIT_W-1:0]    wr_data,
  input  logic [NUM_DIGITS-1:0] blank_mask,
`ifdef DISP_BRIGHT_EN
  input  logic [3:0]            brightness,
`endif
  output logic [DIGIT_W-1:0]    digit_val,
  output logic [IW-1:0]         digit_idx,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  scan_wrap
);

  localparam int MAX_CNT = max_int(CLK_DIV, GUARD_CYC);
  localparam int CW      = $clog2(MAX_CNT);

  scan_state_t           state;
  logic [DIGIT_W-1:0]    digit_reg [NUM_DIGITS];
  logic [CW-1:0]         limit;
  logic [CW-1:0]         cnt_next;
  logic                  tc;
  logic                  lit_next;
  logic                  last_digit;
  logic [NUM_DIGITS-1:0] an_drive;

  // Host writes; an index with no matching register simply hits nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_idx == IW'(i)) digit_reg[i] <= wr_data;
      end
    end
  end

  assign digit_val = digit_reg[digit_idx];

  assign limit      = (state == GUARD) ? CW'(GUARD_CYC - 1) : CW'(CLK_DIV - 1);
  assign last_digit = (digit_idx == IW'(NUM_DIGITS - 1));

  disp_dwell_cnt #(
    .MAX_CNT (MAX_CNT)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .limit    (limit),
    .cnt_next (cnt_next),
    .tc       (tc)
  );

`ifdef DISP_BRIGHT_EN
  // Duty compare is done at a width that holds 16*CLK_DIV without overflow.
  localparam int BW = $clog2(CLK_DIV) + 5;

  logic [3:0]    bright_q;
  logic [3:0]    bright_sel;
  logic [BW-1:0] duty_lhs;
  logic [BW-1:0] duty_rhs;

  // Entering DRIVE the fresh brightness applies; inside DRIVE the latched one.
  assign bright_sel = (state == GUARD) ? brightness : bright_q;
  assign duty_lhs   = BW'(cnt_next) << 4;
  assign duty_rhs   = (BW'(bright_sel) + BW'(1)) * BW'(CLK_DIV);
  assign lit_next   = (duty_lhs < duty_rhs);

  // Latch brightness once per digit so the duty is stable within a dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    bright_q <= '0;
    else if (state == GUARD && tc) bright_q <= brightness;
  end
`else
  logic unused_cnt_next;
  assign unused_cnt_next = ^cnt_next;
  assign lit_next        = 1'b1;
`endif

  // Enable pattern for the next DRIVE cycle: only the active digit may light.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
    assign an_drive[gi] = (digit_idx == IW'(gi)) ? (blank_mask[gi] | ~lit_next) : 1'b1;
  end

  // Scan FSM; an and scan_wrap are registered so the pins never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= GUARD;
      digit_idx <= '0;
      an        <= AN_OFF[NUM_DIGITS-1:0];
      scan_wrap <= 1'b0;
    end else begin
      scan_wrap <= 1'b0;
      case (state)
        GUARD: begin
          if (tc) begin
            state <= DRIVE;
            an    <= an_drive;
          end else begin
            an    <= AN_OFF[NUM_DIGITS-1:0];
          end
        end
        DRIVE: begin
          if (tc) begin
            state     <= GUARD;
            an        <= AN_OFF[NUM_DIGITS-1:0];
            digit_idx <= last_digit ? '0 : digit_idx + 1'b1;
            scan_wrap <= last_digit;
          end else begin
            an        <= an_drive;
          end
        end
        default: begin
          state <= GUARD;
          an    <= AN_OFF[NUM_DIGITS-1:0];
        end
      endcase
    end
  end

endmodule
